// File: rtl/tdm_pkg.sv
// Shared definitions for both ends of the 8-channel TDM serial link.
// Holds FSM state encoding, default frame parameters and the slot-index width helper.
package tdm_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } tdm_state_t;

    localparam int N_CH_DEF        = 8;
    localparam int LOCK_FRAMES_DEF = 2;
    localparam int MISS_MAX_DEF    = 2;

    // Width needed to count 0..n-1, never narrower than one bit.
    function automatic int sw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot position counter: advances per beat with wrap, loads slot 1 on a hunt-time sync, clears on lock loss.
// Zero latency on last_slot (decoded from the current count); no backpressure, steps whenever adv is high.
module tdm_slot_ctr
    import tdm_pkg::*;
#(
    parameter int  N_CH = N_CH_DEF,
    localparam int SW   = sw_of(N_CH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          adv,
    input  logic          load,
    input  logic          clr,
    output logic [SW-1:0] slot,
    output logic          last_slot
);

    localparam logic [SW-1:0] LAST = SW'(N_CH - 1);

    assign last_slot = (slot == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (clr) begin
            slot <= '0;
        end else if (load) begin
            // The sync beat itself occupied slot 0, so the next beat is slot 1.
            slot <= SW'(1);
        end else if (adv) begin
            slot <= last_slot ? '0 : slot + 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux8.sv
// TDM receiver: rebuilds N_CH-bit frames from one bit per beat and acquires/holds frame lock.
// Frame word and dout_valid appear one cycle after the last-slot beat; no backpressure, every din_valid beat is consumed.
module tdm_demux8
    import tdm_pkg::*;
#(
    parameter int  N_CH        = N_CH_DEF,
    parameter int  LOCK_FRAMES = LOCK_FRAMES_DEF,
    parameter int  MISS_MAX    = MISS_MAX_DEF,
    localparam int SW          = sw_of(N_CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            din,
    input  logic            din_valid,
    input  logic            fsync,
    output logic [N_CH-1:0] dout,
    output logic            dout_valid,
    output logic            locked,
    output logic            sync_err,
    output logic [SW-1:0]   slot
);

    localparam int GW = sw_of(LOCK_FRAMES + 1);
    localparam int MW = sw_of(MISS_MAX + 1);

    tdm_state_t      state;
    logic [N_CH-1:0] shadow;
    logic [N_CH-1:0] shadow_nxt;
    logic [GW-1:0]   good_cnt;
    logic [GW-1:0]   good_inc;
    logic [MW-1:0]   miss_cnt;
    logic [MW-1:0]   miss_inc;
    logic            frame_miss;
    logic            frame_bad;
    logic            last_slot;
    logic            miss;
    logic            hunt_sync;
    logic            drop_lock;
    logic [SW-1:0]   wr_idx;

    assign miss      = (slot == '0) ? ~fsync : fsync;
    assign hunt_sync = (state == HUNT) && din_valid && fsync;
    assign frame_bad = frame_miss | miss;
    assign good_inc  = good_cnt + 1'b1;
    assign miss_inc  = miss_cnt + 1'b1;
    assign drop_lock = (state == LOCKED) && din_valid && last_slot &&
                       frame_bad && (miss_inc == MW'(MISS_MAX));
    assign wr_idx    = hunt_sync ? '0 : slot;

    // Next shadow includes the current beat so a delivered frame carries its last bit.
    always_comb begin
        shadow_nxt = shadow;
        if (din_valid) begin
            shadow_nxt[wr_idx] = din;
        end
    end

    tdm_slot_ctr #(
        .N_CH (N_CH)
    ) u_slot_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .adv       (din_valid),
        .load      (hunt_sync),
        .clr       (drop_lock),
        .slot      (slot),
        .last_slot (last_slot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            shadow     <= '0;
            good_cnt   <= '0;
            miss_cnt   <= '0;
            frame_miss <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            locked     <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            sync_err   <= 1'b0;
            if (din_valid) begin
                shadow <= shadow_nxt;
                case (state)
                    HUNT: begin
                        if (fsync) begin
                            state    <= CONFIRM;
                            good_cnt <= '0;
                        end
                    end
                    CONFIRM: begin
                        if (miss) begin
                            state <= HUNT;
                        end else if (last_slot) begin
                            if (good_inc == GW'(LOCK_FRAMES)) begin
                                state      <= LOCKED;
                                locked     <= 1'b1;
                                miss_cnt   <= '0;
                                frame_miss <= 1'b0;
                            end else begin
                                good_cnt <= good_inc;
                            end
                        end
                    end
                    LOCKED: begin
                        if (last_slot) begin
                            frame_miss <= 1'b0;
                            if (drop_lock) begin
                                state    <= HUNT;
                                locked   <= 1'b0;
                                sync_err <= 1'b1;
                                miss_cnt <= '0;
                            end else begin
                                // Flywheel: a frame with misses is still delivered until MISS_MAX.
                                miss_cnt   <= frame_bad ? miss_inc : '0;
                                dout       <= shadow_nxt;
                                dout_valid <= 1'b1;
                            end
                        end else if (miss) begin
                            frame_miss <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux8.sv
// Self-checking bench for tdm_demux8: scripted frames with per-frame expectations and a delivery scoreboard.
module tb_tdm_demux8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din;
    logic       din_valid;
    logic       fsync;
    logic [7:0] dout;
    logic       dout_valid;
    logic       locked;
    logic       sync_err;
    logic [2:0] slot;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] last_dout  = '0;
    logic       exp_strobe = 1'b0;
    logic       exp_err    = 1'b0;
    logic       exp_locked = 1'b0;
    logic       mon_en     = 1'b0;

    tdm_demux8 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .fsync      (fsync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .locked     (locked),
        .sync_err   (sync_err),
        .slot       (slot)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Outputs are sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            check("dout_valid", 32'(dout_valid), 32'(exp_strobe));
            check("sync_err", 32'(sync_err), 32'(exp_err));
            check("locked", 32'(locked), 32'(exp_locked));
            if (dout_valid && exp_q.size() > 0) begin
                last_dout = exp_q.pop_front();
                check("dout", 32'(dout), 32'(last_dout));
            end else begin
                check("dout_hold", 32'(dout), 32'(last_dout));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din_valid  = 1'b0;
            din        = 1'($urandom_range(0, 1));
            fsync      = 1'($urandom_range(0, 1));
            exp_strobe = 1'b0;
            exp_err    = 1'b0;
        end
    endtask

    task automatic beat(input logic d, input logic f);
        @(negedge clk);
        din_valid  = 1'b1;
        din        = d;
        fsync      = f;
        exp_strobe = 1'b0;
        exp_err    = 1'b0;
    endtask

    // One frame; dlv/err/lk are the expected strobe, sync_err and locked after its last beat.
    task automatic send_frame(input logic [7:0] data, input logic [7:0] fmask, input int max_gap,
                              input bit dlv, input bit err, input bit lk);
        for (int k = 0; k < 8; k++) begin
            idle((max_gap > 0) ? $urandom_range(0, max_gap) : 0);
            if (k < 7) begin
                beat(data[k], fmask[k]);
            end else begin
                @(negedge clk);
                din_valid  = 1'b1;
                din        = data[7];
                fsync      = fmask[7];
                exp_strobe = dlv;
                exp_err    = err;
                exp_locked = lk;
                if (dlv) exp_q.push_back(data);
            end
        end
    endtask

    initial begin
        logic [7:0] part;
        rst_n     = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;
        fsync     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_dout_valid", 32'(dout_valid), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_sync_err", 32'(sync_err), 32'h0);
        check("rst_slot", 32'(slot), 32'h0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Acquisition: lock after frame 2, first delivery is frame 3.
        send_frame(8'hA5, 8'h01, 0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 8'h01, 0, 1'b0, 1'b0, 1'b1);
        send_frame(8'hA5, 8'h01, 0, 1'b1, 1'b0, 1'b1);

        // Locked with idle gaps between beats.
        send_frame(8'h01, 8'h01, 3, 1'b1, 1'b0, 1'b1);
        send_frame(8'h80, 8'h01, 3, 1'b1, 1'b0, 1'b1);
        send_frame(8'hFF, 8'h01, 3, 1'b1, 1'b0, 1'b1);

        // Single missing sync is flywheeled; a clean frame clears the miss count.
        send_frame(8'h3C, 8'h00, 1, 1'b1, 1'b0, 1'b1);
        send_frame(8'h5A, 8'h01, 1, 1'b1, 1'b0, 1'b1);
        send_frame(8'h66, 8'h00, 1, 1'b1, 1'b0, 1'b1);
        send_frame(8'h99, 8'h01, 1, 1'b1, 1'b0, 1'b1);

        // Two consecutive bad frames: first delivered, second drops lock.
        send_frame(8'h12, 8'h08, 0, 1'b1, 1'b0, 1'b1);
        send_frame(8'h34, 8'h08, 0, 1'b0, 1'b1, 1'b0);
        idle(1);
        check("slot_after_drop", 32'(slot), 32'h0);

        // Relock after two clean frames.
        send_frame(8'hC3, 8'h01, 2, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 8'h01, 2, 1'b0, 1'b0, 1'b1);
        send_frame(8'h81, 8'h01, 2, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a locked frame.
        part = 8'h77;
        for (int k = 0; k < 4; k++) beat(part[k], (k == 0));
        idle(1);
        check("slot_mid", 32'(slot), 32'h4);
        #2;
        rst_n      = 1'b0;
        exp_locked = 1'b0;
        last_dout  = '0;
        exp_q.delete();
        #1;
        check("arst_dout", 32'(dout), 32'h0);
        check("arst_dout_valid", 32'(dout_valid), 32'h0);
        check("arst_locked", 32'(locked), 32'h0);
        check("arst_sync_err", 32'(sync_err), 32'h0);
        check("arst_slot", 32'(slot), 32'h0);
        idle(2);
        rst_n = 1'b1;
        for (int k = 4; k < 8; k++) beat(part[k], 1'b0);

        // Stray sync at slot 5 while confirming sends the FSM back to hunting.
        send_frame(8'h55, 8'h21, 0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h0F, 8'h01, 1, 1'b0, 1'b0, 1'b0);
        send_frame(8'hF0, 8'h01, 1, 1'b0, 1'b0, 1'b1);
        send_frame(8'hE7, 8'h01, 1, 1'b1, 1'b0, 1'b1);

        idle(4);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
